// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port between two producers.
// Define FIFO_ARB_STATS_EN to add the per-producer accepted-word counters.
module fifo_wr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    input  logic       fifo_full,
    output logic       fifo_wr,
    output logic [7:0] fifo_data,
    output logic [1:0] grant
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0] wr_cnt0,
    output logic [15:0] wr_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic [3:0] BLAST = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] bcnt_q, bcnt_d;
    logic       own_req, oth_req, own_ack, done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            bcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        own_req = (state_q == GNT1) ? req1 : req0;
        oth_req = (state_q == GNT1) ? req0 : req1;
        own_ack = ack0 | ack1;
        done    = (own_ack & (bcnt_q == BLAST)) | ~own_req;
        unique case (state_q)
            IDLE: begin
                if (req0 & (~req1 | last_q)) state_d = GNT0;
                else if (req1)               state_d = GNT1;
            end
            GNT0, GNT1: begin
                if (done) begin
                    bcnt_d = 4'd0;
                    if (oth_req)
                        state_d = (state_q == GNT0) ? GNT1 : GNT0;
                    else if (!own_req)
                        state_d = IDLE;
                end else if (own_ack) begin
                    bcnt_d = bcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // pointer follows every fresh entry into a grant state
        if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
        if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;
    end

    always_comb begin
        ack0      = 1'b0;
        ack1      = 1'b0;
        fifo_data = 8'h00;
        unique case (state_q)
            GNT0: begin
                ack0      = req0 & ~fifo_full;
                fifo_data = data0;
            end
            GNT1: begin
                ack1      = req1 & ~fifo_full;
                fifo_data = data1;
            end
            default: ;
        endcase
        fifo_wr = ack0 | ack1;
        grant   = state_q;
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] wr_cnt0_q, wr_cnt0_d;
    logic [15:0] wr_cnt1_q, wr_cnt1_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt0_q <= 16'd0;
            wr_cnt1_q <= 16'd0;
        end else begin
            wr_cnt0_q <= wr_cnt0_d;
            wr_cnt1_q <= wr_cnt1_d;
        end
    end

    always_comb begin
        wr_cnt0_d = wr_cnt0_q + {15'd0, ack0};
        wr_cnt1_d = wr_cnt1_q + {15'd0, ack1};
    end

    assign wr_cnt0 = wr_cnt0_q;
    assign wr_cnt1 = wr_cnt1_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: randomized producers and full flag,
// expected per-cycle outputs come from a behavioural arbitration model.
module tb_fifo_wr_arbiter;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       ack0, ack1, fifo_full = 1'b0, fifo_wr;
    logic [7:0] fifo_data;
    logic [1:0] grant;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] wr_cnt0, wr_cnt1;
`endif

    fifo_wr_arbiter #(.MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr),
        .fifo_data(fifo_data), .grant(grant)
`ifdef FIFO_ARB_STATS_EN
        , .wr_cnt0(wr_cnt0), .wr_cnt1(wr_cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  g;
        logic        a0, a1, wr;
        logic [7:0]  d;
        logic [15:0] c0, c1;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Model: who owns the port (-1 none), words taken in this grant, pointer
    int   owner = -1;
    int   used  = 0;
    int   last  = 1;
    bit   pend[2];
    bit   acked[2];
    logic [7:0] word[2];
    logic [15:0] cnt[2];

    task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1; used = 0; last = 1;
        acked[0] = 0; acked[1] = 0;
        cnt[0] = 0; cnt[1] = 0;
    endtask

    task automatic step(bit rlo, int p0, int p1, int fp, int dp);
        exp_t e;
        bit   a[2];
        bit   full;
        int   pr[2];
        int   oth;
        bit   done;
        pr[0] = p0; pr[1] = p1;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (acked[p]) pend[p] = 0;
            if (!pend[p]) begin
                pend[p] = ($urandom_range(99) < pr[p]);
                if (pend[p]) word[p] = 8'($urandom);
            end else if ($urandom_range(99) < dp) begin
                pend[p] = 0;
            end
        end
        full = ($urandom_range(99) < fp);
        req0 = pend[0]; data0 = word[0];
        req1 = pend[1]; data1 = word[1];
        fifo_full = full;
        rst = !rlo;
        if (rlo) begin
            model_reset();
            e = '{g: 2'b00, a0: 0, a1: 0, wr: 0, d: 8'h00, c0: 0, c1: 0};
            q.push_back(e);
            return;
        end
        for (int p = 0; p < 2; p++)
            a[p] = (owner == p) && pend[p] && !full;
        e.g  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        e.a0 = a[0];
        e.a1 = a[1];
        e.wr = a[0] | a[1];
        e.d  = (owner >= 0) ? word[owner] : 8'h00;
        e.c0 = cnt[0];
        e.c1 = cnt[1];
        q.push_back(e);
        for (int p = 0; p < 2; p++) begin
            if (a[p]) cnt[p] = cnt[p] + 16'd1;
            acked[p] = a[p];
        end
        if (owner < 0) begin
            if (pend[0] && pend[1]) owner = 1 - last;
            else if (pend[0])       owner = 0;
            else if (pend[1])       owner = 1;
            if (owner >= 0) begin last = owner; used = 0; end
        end else begin
            if (a[owner]) used++;
            done = (a[owner] && used == MB) || !pend[owner];
            oth  = 1 - owner;
            if (done) begin
                used = 0;
                if (pend[oth]) begin owner = oth; last = oth; end
                else if (!pend[owner]) owner = -1;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("grant", {14'd0, grant}, {14'd0, e.g});
            chk("ack0", {15'd0, ack0}, {15'd0, e.a0});
            chk("ack1", {15'd0, ack1}, {15'd0, e.a1});
            chk("fifo_wr", {15'd0, fifo_wr}, {15'd0, e.wr});
            chk("fifo_data", {8'd0, fifo_data}, {8'd0, e.d});
`ifdef FIFO_ARB_STATS_EN
            chk("wr_cnt0", wr_cnt0, e.c0);
            chk("wr_cnt1", wr_cnt1, e.c1);
`endif
        end
    end

    initial begin
        pend[0] = 0; pend[1] = 0;
        word[0] = 8'h00; word[1] = 8'h00;
        model_reset();
        repeat (2)  step(1, 0, 0, 0, 0);
        repeat (12) step(0, 100, 0, 0, 0);
        repeat (3)  step(0, 0, 0, 0, 100);
        repeat (26) step(0, 100, 100, 0, 0);
        repeat (3)  step(0, 100, 100, 100, 0);
        repeat (10) step(0, 100, 100, 0, 0);
        repeat (3)  step(0, 0, 0, 0, 100);
        repeat (4)  step(0, 0, 100, 0, 0);
        repeat (2)  step(1, 100, 100, 0, 0);
        repeat (6)  step(0, 100, 100, 0, 0);
        repeat (4000)
            step($urandom_range(299) == 0, 60, 50, 25, 5);
`ifdef FIFO_ARB_STATS_EN
        repeat (2) step(1, 0, 0, 0, 0);
        repeat (70100) step(0, 100, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 100);
        repeat (20) step(0, 0, 100, 0, 0);
`endif
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 16'(q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
